capture_arbiter: RTL and testbench

CAPTURE_ARBITER -- requirements
Module: capture_arbiter

---
 rtl/capture_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_capture_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_arbiter.sv
// Two-channel logic capture engine: samples sig0/sig1 into a byte buffer after an
// arm command, then streams a header, the channel mask and the captured bytes to a UART.
module capture_arbiter #(
  parameter int         DEPTH = 16,
  parameter int         DECIM = 4,
  parameter logic [7:0] HDR   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig0,
  input  logic       sig1,
  input  logic       blank,
  input  logic       cmd_stb,
  input  logic [7:0] cmd_dat,
  input  logic       tx_busy,
  output logic       tx_stb,
  output logic [7:0] tx_dat,
  output logic       busy,
  output logic [1:0] chan,
  output logic [2:0] dbg_state
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int IW = $clog2(DEPTH) + 1;
  localparam int AW = IW - 1;
  localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
  localparam logic [IW-1:0] WIDX_LAST = IW'(DEPTH - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(DEPTH - 1);
  localparam logic [IW-1:0] IDX_BOTH  = IW'(2 * DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPTURE, S_HDR, S_SEND, S_WAIT} state_t;
  typedef enum logic [1:0] {PH_HDR, PH_CHAN, PH_DATA} phase_t;

  // tx_stb/tx_dat are valid together for exactly one cycle; the sink signals it cannot
  // take a byte by holding tx_busy high, and a byte is only launched when tx_busy was low.

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [1:0]    chan_q, chan_d;
  logic [DW-1:0] dec_q, dec_d;
  logic [2:0]    bit_q, bit_d;
  logic [6:0]    sh0_q, sh0_d, sh1_q, sh1_d;
  logic [IW-1:0] widx_q, widx_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          last_q, last_d;
  logic          tx_stb_q, tx_stb_d;
  logic [7:0]    tx_dat_q, tx_dat_d;
  logic          busy_q, busy_d;

  logic [7:0]    buf0_q [DEPTH];
  logic [7:0]    buf1_q [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          rd_sel1, abort;
  logic [7:0]    rd_byte;

  assign wr_addr = widx_q[AW-1:0];
  // Interleaved mode walks ch0/ch1 alternately, so the LSB picks the channel.
  assign rd_addr = (chan_q == 2'b11) ? idx_q[IW-1:1] : idx_q[AW-1:0];
  assign rd_sel1 = (chan_q == 2'b10) || ((chan_q == 2'b11) && idx_q[0]);
  assign rd_byte = rd_sel1 ? buf1_q[rd_addr] : buf0_q[rd_addr];
  assign abort   = cmd_stb && (cmd_dat == 8'h58);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    chan_d   = chan_q;
    dec_d    = dec_q;
    bit_d    = bit_q;
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    widx_d   = widx_q;
    idx_d    = idx_q;
    last_d   = last_q;
    tx_stb_d = 1'b0;
    tx_dat_d = tx_dat_q;
    wr_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_stb) begin
          case (cmd_dat)
            8'h30:   begin chan_d = 2'b01; state_d = S_ARM; end
            8'h31:   begin chan_d = 2'b10; state_d = S_ARM; end
            8'h42:   begin chan_d = 2'b11; state_d = S_ARM; end
            default: ;
          endcase
          dec_d   = '0;
          bit_d   = '0;
          sh0_d   = '0;
          sh1_d   = '0;
          widx_d  = '0;
          idx_d   = '0;
          last_d  = 1'b0;
          phase_d = PH_HDR;
        end
      end
      S_ARM: if (!blank) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (!blank) begin
          dec_d = (dec_q == DEC_LAST) ? '0 : dec_q + DW'(1);
          if (dec_q == '0) begin
            sh0_d = {sh0_q[5:0], sig0};
            sh1_d = {sh1_q[5:0], sig1};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              wr_en = 1'b1;
              if (widx_q == WIDX_LAST) begin
                widx_d  = '0;
                state_d = S_HDR;
                phase_d = PH_HDR;
              end else begin
                widx_d = widx_q + IW'(1);
              end
            end
          end
        end
      end
      S_HDR: begin
        if (!tx_busy) begin
          tx_stb_d = 1'b1;
          tx_dat_d = (phase_q == PH_HDR) ? HDR : {6'b0, chan_q};
          state_d  = S_WAIT;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_stb_d = 1'b1;
          tx_dat_d = rd_byte;
          state_d  = S_WAIT;
          if (idx_q == ((chan_q == 2'b11) ? IDX_BOTH : IDX_ONE)) last_d = 1'b1;
          else idx_d = idx_q + IW'(1);
        end
      end
      S_WAIT: begin
        case (phase_q)
          PH_HDR:  begin phase_d = PH_CHAN; state_d = S_HDR;  end
          PH_CHAN: begin phase_d = PH_DATA; state_d = S_SEND; end
          default: begin
            if (last_q) begin
              state_d = S_IDLE;
              chan_d  = 2'b00;
            end else begin
              state_d = S_SEND;
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      chan_d   = 2'b00;
      tx_stb_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_HDR;
      chan_q   <= 2'b00;
      dec_q    <= '0;
      bit_q    <= '0;
      sh0_q    <= '0;
      sh1_q    <= '0;
      widx_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      tx_stb_q <= 1'b0;
      tx_dat_q <= 8'h00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      chan_q   <= chan_d;
      dec_q    <= dec_d;
      bit_q    <= bit_d;
      sh0_q    <= sh0_d;
      sh1_q    <= sh1_d;
      widx_q   <= widx_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      tx_stb_q <= tx_stb_d;
      tx_dat_q <= tx_dat_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      buf0_q[wr_addr] <= {sh0_q, sig0};
      buf1_q[wr_addr] <= {sh1_q, sig1};
    end
  end

  assign tx_stb    = tx_stb_q;
  assign tx_dat    = tx_dat_q;
  assign busy      = busy_q;
  assign chan      = chan_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_capture_arbiter.sv
// Scoreboard bench for capture_arbiter: frames are predicted from the per-sample bit
// streams the driver applies; a monitor pops and compares every tx_stb byte.
module tb_capture_arbiter;
  localparam int         DEPTH = 4;
  localparam int         DECIM = 2;
  localparam logic [7:0] HDR   = 8'hA5;
  localparam int         NB    = 8 * DEPTH;

  logic       clk, rst, sig0, sig1, blank, cmd_stb, tx_busy, tx_stb, busy;
  logic [7:0] cmd_dat, tx_dat;
  logic [1:0] chan;
  logic [2:0] dbg_state;

  logic [7:0] exp_q[$];
  int         errors = 0, checks = 0, rx_cnt = 0;
  int         busy_lo = 0, busy_hi = 2, busy_cnt = 0;
  logic       prev_stb = 1'b0;
  logic       s0_bits [NB];
  logic       s1_bits [NB];

  capture_arbiter #(.DEPTH(DEPTH), .DECIM(DECIM), .HDR(HDR)) dut (
    .clk(clk), .rst(rst), .sig0(sig0), .sig1(sig1), .blank(blank),
    .cmd_stb(cmd_stb), .cmd_dat(cmd_dat), .tx_busy(tx_busy),
    .tx_stb(tx_stb), .tx_dat(tx_dat), .busy(busy), .chan(chan), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // UART model: busy for a random number of cycles after each byte
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (!rst) busy_cnt <= 0;
    else if (tx_stb === 1'b1) busy_cnt <= int'($urandom_range(busy_hi, busy_lo));
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_stb === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_stb: got byte %0h expected no strobe", tx_dat);
        end else begin
          check("tx_dat", 32'(tx_dat), 32'(exp_q.pop_front()));
        end
        rx_cnt++;
        check("stb_while_busy", 32'(tx_busy), 32'd0);
        check("stb_width", 32'(prev_stb), 32'd0);
      end
      prev_stb = tx_stb;
    end
  end

  // driver tasks
  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_stb = 1'b0;
      blank   = 1'(($urandom_range(0, 3)) == 0);
      sig0    = 1'($urandom_range(0, 1));
      sig1    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NB; i++) begin
      s0_bits[i] = 1'($urandom_range(0, 1));
      s1_bits[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_busy_low(input string name);
    bit done = 0;
    for (int c = 0; c < 20000 && !done; c++) begin
      if (busy === 1'b0) done = 1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: busy still high after timeout, expected low", name);
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int arm_hold, input int blank_at,
                           input int blank_len, input int abort_after, input bit final_cmd);
    logic [1:0] mask;
    logic [7:0] b0 [DEPTH];
    logic [7:0] b1 [DEPTH];
    logic [7:0] stray;
    int active, k, blanked, start_rx, total;
    bit done;
    mask = (cmd == 8'h30) ? 2'b01 : (cmd == 8'h31) ? 2'b10 : 2'b11;
    for (int j = 0; j < DEPTH; j++) begin
      b0[j] = 8'h00;
      b1[j] = 8'h00;
      for (int b = 0; b < 8; b++) begin
        b0[j] = {b0[j][6:0], s0_bits[8*j+b]};
        b1[j] = {b1[j][6:0], s1_bits[8*j+b]};
      end
    end
    exp_q.push_back(HDR);
    exp_q.push_back({6'b0, mask});
    for (int j = 0; j < DEPTH; j++) begin
      if (mask[0]) exp_q.push_back(b0[j]);
      if (mask[1]) exp_q.push_back(b1[j]);
    end
    total    = 2 + ((mask == 2'b11) ? 2 * DEPTH : DEPTH);
    start_rx = rx_cnt;

    @(negedge clk);
    cmd_stb = 1'b1;
    cmd_dat = cmd;
    blank   = 1'($urandom_range(0, 1));
    for (int i = 0; i < arm_hold; i++) begin
      @(negedge clk);
      cmd_stb = 1'b0;
      blank   = 1'b1;
      sig0    = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    cmd_stb = 1'b0;
    blank   = 1'b0;
    active = 0; k = 0; blanked = 0;
    while (k < NB) begin
      @(negedge clk);
      cmd_stb = 1'b0;
      sig0    = 1'($urandom_range(0, 1));
      sig1    = 1'($urandom_range(0, 1));
      if (active == blank_at && blanked < blank_len) begin
        blank = 1'b1;
        blanked++;
      end else begin
        blank = 1'b0;
        if (active % DECIM == 0) begin
          sig0 = s0_bits[k];
          sig1 = s1_bits[k];
          k++;
        end
        active++;
        if (active == 3) begin
          stray   = 8'($urandom_range(0, 255));
          cmd_stb = 1'b1;
          cmd_dat = (stray == 8'h58) ? 8'h30 : stray;
        end
      end
    end
    @(negedge clk);
    cmd_stb = 1'b0;
    blank   = 1'b0;
    check("chan", 32'(chan), 32'(mask));

    if (abort_after > 0 || final_cmd) begin
      done = 0;
      for (int c = 0; c < 20000 && !done; c++) begin
        if (rx_cnt >= start_rx + ((abort_after > 0) ? abort_after : total)) done = 1;
        else @(negedge clk);
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL byte_wait: got %0d bytes expected %0d", rx_cnt - start_rx, total);
      end
      cmd_stb = 1'b1;
      cmd_dat = (abort_after > 0) ? 8'h58 : 8'h31;
      @(negedge clk);
      cmd_stb = 1'b0;
      if (abort_after > 0) begin
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_chan", 32'(chan), 32'd0);
        exp_q.delete();
        drive_idle(30);
        check("abort_quiet_busy", 32'(busy), 32'd0);
        return;
      end
    end
    wait_busy_low("frame_end");
    drive_idle(5);
    check("idle_after_frame", 32'(busy), 32'd0);
    check("frame_drained", 32'(exp_q.size()), 32'd0);
    check("frame_bytes", 32'(rx_cnt - start_rx), 32'(total));
  endtask

  // main sequence
  initial begin
    rst = 1'b0; sig0 = 1'b0; sig1 = 1'b0; blank = 1'b0; cmd_stb = 1'b0; cmd_dat = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx_stb", 32'(tx_stb), 32'd0);
    check("rst_tx_dat", 32'(tx_dat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_chan", 32'(chan), 32'd0);
    rst = 1'b1;

    // unknown and abort bytes in IDLE do nothing
    @(negedge clk); cmd_stb = 1'b1; cmd_dat = 8'h55;
    @(negedge clk); cmd_dat = 8'h58;
    @(negedge clk); cmd_stb = 1'b0;
    drive_idle(2);
    check("ignored_cmd_busy", 32'(busy), 32'd0);

    // ch0 only, 1010... pattern
    busy_lo = 0; busy_hi = 0;
    for (int i = 0; i < NB; i++) begin
      s0_bits[i] = (i % 2 == 0);
      s1_bits[i] = 1'($urandom_range(0, 1));
    end
    run_frame(8'h30, 0, -1, 0, 0, 0);

    // both channels, sig0=1 sig1=0
    busy_lo = 0; busy_hi = 3;
    for (int i = 0; i < NB; i++) begin
      s0_bits[i] = 1'b1;
      s1_bits[i] = 1'b0;
    end
    run_frame(8'h42, 2, -1, 0, 0, 0);

    // 100-cycle blank in the middle of a capture
    fill_random();
    run_frame(8'h31, 1, 9, 100, 0, 0);

    // slow transmitter
    busy_lo = 50; busy_hi = 50;
    fill_random();
    run_frame(8'h42, 0, -1, 0, 0, 0);

    // abort after three bytes, then a fresh ch1 frame
    busy_lo = 0; busy_hi = 3;
    fill_random();
    run_frame(8'h42, 0, 5, 4, 3, 0);
    fill_random();
    run_frame(8'h31, 0, -1, 0, 0, 0);

    // command coinciding with the last byte's WAIT is dropped
    fill_random();
    run_frame(8'h30, 1, -1, 0, 0, 1);

    // reset in the middle of a capture
    @(negedge clk); cmd_stb = 1'b1; cmd_dat = 8'h42; blank = 1'b0;
    drive_idle(6);
    @(negedge clk); cmd_stb = 1'b1; cmd_dat = 8'h30;
    @(negedge clk); cmd_stb = 1'b0;
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_tx_stb", 32'(tx_stb), 32'd0);
    check("mid_rst_tx_dat", 32'(tx_dat), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_chan", 32'(chan), 32'd0);
    drive_idle(40);
    check("post_rst_busy", 32'(busy), 32'd0);

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      logic [7:0] c;
      int sel;
      sel = int'($urandom_range(0, 2));
      c = (sel == 0) ? 8'h30 : (sel == 1) ? 8'h31 : 8'h42;
      busy_lo = 0;
      busy_hi = int'($urandom_range(0, 4));
      fill_random();
      if ($urandom_range(0, 1) == 1)
        run_frame(c, int'($urandom_range(0, 3)), int'($urandom_range(1, 40)),
                  int'($urandom_range(1, 20)), 0, 0);
      else
        run_frame(c, int'($urandom_range(0, 3)), -1, 0, 0, 0);
    end

    drive_idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
